instruction_fetch_unit: RTL and testbench

//  Fetch stage in front of the program memory. Holds the word-addressed PC and drives it to the memory address port.

---
 rtl/instruction_fetch_unit_if.sv | 31 +++
 rtl/instruction_fetch_unit.sv | 109 ++++++++++
 tb/tb_instruction_fetch_unit.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus: decode control in, program-memory port, IF/ID register out.
// The master side is the pipeline/memory environment; the slave side is the fetch unit.
// Widths follow the fetch unit's WIDTH / ADD_WIDTH parameters.
interface instruction_fetch_unit_if #(
  parameter int WIDTH     = 32,
  parameter int ADD_WIDTH = 8
);
  logic                 stall;
  logic                 redirect;
  logic [ADD_WIDTH-1:0] redirect_pc;
  logic [WIDTH-1:0]     instruction_in;
  logic [ADD_WIDTH-1:0] pc_out;
  logic [WIDTH-1:0]     if_id_instr;
  logic [ADD_WIDTH-1:0] if_id_pc;
  logic                 if_id_valid;
  logic                 halted;
  logic [15:0]          fetch_count;
  logic [15:0]          stall_count;

  modport master (
    output stall, redirect, redirect_pc, instruction_in,
    input  pc_out, if_id_instr, if_id_pc, if_id_valid, halted,
           fetch_count, stall_count
  );

  modport slave (
    input  stall, redirect, redirect_pc, instruction_in,
    output pc_out, if_id_instr, if_id_pc, if_id_valid, halted,
           fetch_count, stall_count
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: drives PC to async program memory, captures word into IF/ID, halts on opcode 7'h7F.
// Latency: memory word appears in IF/ID one clk after its PC is presented on pc_out.
// Backpressure: stall holds PC and IF/ID; redirect overrides stall. FETCH_PERF_CNT_EN adds saturating counters.
module instruction_fetch_unit #(
  parameter int                   WIDTH     = 32,
  parameter int                   ADD_WIDTH = 8,
  parameter logic [ADD_WIDTH-1:0] RESET_PC  = '0,
  parameter logic [WIDTH-1:0]     NOP_INSTR = 'h0000_0013
) (
  input  logic                     clk,
  input  logic                     rst,
  instruction_fetch_unit_if.slave  fetch
);

  localparam logic [6:0] HALT_OPCODE = 7'b1111111;

  typedef enum logic {RUN, HALT} state_t;

  state_t               state_q;
  logic [ADD_WIDTH-1:0] pc_q;
  logic [ADD_WIDTH-1:0] pc_d;
  logic [WIDTH-1:0]     if_id_instr_q;
  logic [ADD_WIDTH-1:0] if_id_pc_q;
  logic                 if_id_valid_q;
  logic                 halted_q;
  logic                 is_halt;
  logic                 load_fire;
  logic                 stall_cycle;

  // Sequential PC wraps naturally at 2^ADD_WIDTH.
  assign pc_d        = pc_q + 1'b1;
  assign is_halt     = (fetch.instruction_in[6:0] == HALT_OPCODE);
  // A real instruction enters IF/ID only in RUN with neither redirect nor stall.
  assign load_fire   = (state_q == RUN) && !fetch.redirect && !fetch.stall;
  assign stall_cycle = (state_q == RUN) && !fetch.redirect &&  fetch.stall;

  // Fetch FSM with PC and IF/ID pipeline register; redirect > stall > normal in RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      if_id_instr_q <= NOP_INSTR;
      if_id_pc_q    <= '0;
      if_id_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (fetch.redirect) begin
            // Word currently on instruction_in is wrong-path: replace with a bubble.
            pc_q          <= fetch.redirect_pc;
            if_id_instr_q <= NOP_INSTR;
            if_id_valid_q <= 1'b0;
          end else if (!fetch.stall) begin
            if_id_instr_q <= fetch.instruction_in;
            if_id_pc_q    <= pc_q;
            if_id_valid_q <= 1'b1;
            if (is_halt) begin
              // Halt word still goes to decode, but the PC freezes on it.
              state_q  <= HALT;
              halted_q <= 1'b1;
            end else begin
              pc_q <= pc_d;
            end
          end
        end
        HALT: begin
          // Only reset leaves HALT; drain IF/ID to bubbles once decode accepts.
          if (!fetch.stall) begin
            if_id_instr_q <= NOP_INSTR;
            if_id_valid_q <= 1'b0;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign fetch.pc_out      = pc_q;
  assign fetch.if_id_instr = if_id_instr_q;
  assign fetch.if_id_pc    = if_id_pc_q;
  assign fetch.if_id_valid = if_id_valid_q;
  assign fetch.halted      = halted_q;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_count_q;
  logic [15:0] stall_count_q;

  // Saturating performance counters for fetched words and decode-stall cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count_q <= '0;
      stall_count_q <= '0;
    end else begin
      if (load_fire && (fetch_count_q != 16'hFFFF)) fetch_count_q <= fetch_count_q + 16'd1;
      if (stall_cycle && (stall_count_q != 16'hFFFF)) stall_count_q <= stall_count_q + 16'd1;
    end
  end

  assign fetch.fetch_count = fetch_count_q;
  assign fetch.stall_count = stall_count_q;
`else
  logic unused_perf;
  assign unused_perf       = load_fire ^ stall_cycle;
  assign fetch.fetch_count = 16'h0000;
  assign fetch.stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: free-run to halt, stall, redirect, wrap, reset-in-halt.
// Program memory is modelled combinationally from pc_out.
// Counter expectations depend on FETCH_PERF_CNT_EN.
module tb_instruction_fetch_unit;

`ifdef FETCH_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic [31:0] mem [0:255];

  instruction_fetch_unit_if #(.WIDTH(32), .ADD_WIDTH(8)) bus ();

  instruction_fetch_unit #(
    .WIDTH(32), .ADD_WIDTH(8), .RESET_PC(8'h00), .NOP_INSTR(32'h0000_0013)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .fetch (bus.slave)
  );

  assign bus.instruction_in = mem[bus.pc_out];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 256; i++) mem[i] = NOP;
    mem[0] = 32'h0080_0093;  // addi x1,x0,8
    mem[1] = 32'h0030_0113;  // addi x2,x0,3
    mem[2] = 32'h0020_81B3;  // add  x3,x1,x2
    mem[3] = 32'h4020_8233;  // sub  x4,x1,x2
    mem[4] = 32'h0020_F2B3;  // and  x5,x1,x2
    mem[5] = 32'h0020_E333;  // or   x6,x1,x2
    mem[6] = 32'h0020_C3B3;  // xor  x7,x1,x2
    mem[7] = 32'h0020_9433;  // sll  x8,x1,x2
    mem[8] = 32'h0020_D4B3;  // srl  x9,x1,x2
    mem[9] = 32'h0000_007F;  // halt

    rst = 1'b1;
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 8'h00;
    @(negedge clk);
    tick();
    tick();

    // Reset state
    check_eq("rst_pc",     {24'b0, bus.pc_out}, 32'h0);
    check_eq("rst_instr",  bus.if_id_instr, NOP);
    check_eq("rst_ifpc",   {24'b0, bus.if_id_pc}, 32'h0);
    check_eq("rst_valid",  {31'b0, bus.if_id_valid}, 32'h0);
    check_eq("rst_halted", {31'b0, bus.halted}, 32'h0);
    check_eq("rst_fcnt",   {16'b0, bus.fetch_count}, 32'h0);
    check_eq("rst_scnt",   {16'b0, bus.stall_count}, 32'h0);

    // Free run to the halt word at address 9
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      check_eq("run_ifpc",  {24'b0, bus.if_id_pc}, k);
      check_eq("run_valid", {31'b0, bus.if_id_valid}, 32'h1);
      check_eq("run_instr", bus.if_id_instr, mem[k]);
      check_eq("run_pc",    {24'b0, bus.pc_out}, (k < 9) ? k + 1 : 9);
      check_eq("run_halt",  {31'b0, bus.halted}, (k < 9) ? 0 : 1);
    end
    check_eq("halt_fcnt", {16'b0, bus.fetch_count}, PERF ? 32'd10 : 32'd0);
    for (int k = 0; k < 2; k++) begin
      tick();
      check_eq("halt_valid", {31'b0, bus.if_id_valid}, 32'h0);
      check_eq("halt_instr", bus.if_id_instr, NOP);
      check_eq("halt_pc",    {24'b0, bus.pc_out}, 32'd9);
    end
    // Redirect is ignored while halted
    bus.redirect = 1'b1;
    bus.redirect_pc = 8'h03;
    tick();
    bus.redirect = 1'b0;
    check_eq("halt_redir_pc", {24'b0, bus.pc_out}, 32'd9);
    check_eq("halt_redir_h",  {31'b0, bus.halted}, 32'h1);

    // Stall for 3 clk while if_id_pc=2
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick(); tick(); tick();
    check_eq("pre_stall_ifpc", {24'b0, bus.if_id_pc}, 32'd2);
    bus.stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("stall_pc",   {24'b0, bus.pc_out}, 32'd3);
      check_eq("stall_ifpc", {24'b0, bus.if_id_pc}, 32'd2);
      check_eq("stall_valid", {31'b0, bus.if_id_valid}, 32'h1);
    end
    bus.stall = 1'b0;
    tick();
    check_eq("post_stall_ifpc",  {24'b0, bus.if_id_pc}, 32'd3);
    check_eq("post_stall_instr", bus.if_id_instr, 32'h4020_8233);
    check_eq("stall_scnt", {16'b0, bus.stall_count}, PERF ? 32'd3 : 32'd0);
    check_eq("stall_fcnt", {16'b0, bus.fetch_count}, PERF ? 32'd4 : 32'd0);

    // Redirect together with stall at pc_out=4
    check_eq("pre_redir_pc", {24'b0, bus.pc_out}, 32'd4);
    bus.redirect = 1'b1;
    bus.stall = 1'b1;
    bus.redirect_pc = 8'h07;
    tick();
    bus.redirect = 1'b0;
    bus.stall = 1'b0;
    check_eq("redir_valid", {31'b0, bus.if_id_valid}, 32'h0);
    check_eq("redir_instr", bus.if_id_instr, NOP);
    check_eq("redir_pc",    {24'b0, bus.pc_out}, 32'd7);
    tick();
    check_eq("redir_ifpc",  {24'b0, bus.if_id_pc}, 32'd7);
    check_eq("redir_valid2", {31'b0, bus.if_id_valid}, 32'h1);
    check_eq("redir_scnt",  {16'b0, bus.stall_count}, PERF ? 32'd3 : 32'd0);

    // PC wrap from 0xFF
    bus.redirect = 1'b1;
    bus.redirect_pc = 8'hFF;
    tick();
    bus.redirect = 1'b0;
    check_eq("wrap_pc_ff", {24'b0, bus.pc_out}, 32'hFF);
    tick();
    check_eq("wrap_ifpc_ff", {24'b0, bus.if_id_pc}, 32'hFF);
    check_eq("wrap_pc_00",   {24'b0, bus.pc_out}, 32'h00);
    tick();
    check_eq("wrap_ifpc_00", {24'b0, bus.if_id_pc}, 32'h00);
    check_eq("wrap_instr",   bus.if_id_instr, mem[0]);

    // Run into halt again, then pulse reset while halted
    for (int k = 1; k < 10; k++) tick();
    check_eq("halt2", {31'b0, bus.halted}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rh_halted", {31'b0, bus.halted}, 32'h0);
    check_eq("rh_pc",     {24'b0, bus.pc_out}, 32'h0);
    check_eq("rh_valid",  {31'b0, bus.if_id_valid}, 32'h0);
    check_eq("rh_fcnt",   {16'b0, bus.fetch_count}, 32'h0);
    check_eq("rh_scnt",   {16'b0, bus.stall_count}, 32'h0);
    tick();
    check_eq("rh_ifpc",  {24'b0, bus.if_id_pc}, 32'h0);
    check_eq("rh_instr", bus.if_id_instr, mem[0]);
    check_eq("rh_valid2", {31'b0, bus.if_id_valid}, 32'h1);

    // Long halt-free run: counter saturation (or stays zero without the counters)
    mem[9] = NOP;
    if (PERF) begin
      for (int k = 0; k < 70000; k++) tick();
    end else begin
      for (int k = 0; k < 300; k++) tick();
    end
    check_eq("sat_fcnt", {16'b0, bus.fetch_count}, PERF ? 32'hFFFF : 32'h0);
    check_eq("sat_scnt", {16'b0, bus.stall_count}, 32'h0);
    check_eq("sat_halt", {31'b0, bus.halted}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
